// File: rtl/alu_multicycle.sv
// Multi-cycle RV32IM execute ALU: single-cycle ops plus MUL, compares and an
// iterative restoring divider, with valid/ready handshakes on both sides.
module alu_multicycle #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter bit ENABLE_DIV    = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    ALUResult,
  output logic                     Zero
);

  localparam int SW = $clog2(DATA_WIDTH);
  localparam int CW = SW + 1;
  localparam logic [CW-1:0]         CNT_LOAD = CW'(DATA_WIDTH);
  localparam logic [CW-1:0]         CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] ZERO_V   = {DATA_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] ONES_V   = {DATA_WIDTH{1'b1}};
  localparam logic [DATA_WIDTH-1:0] MIN_V    = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, DIV = 2'd1, DONE = 2'd2} state_t;

  function automatic logic [DATA_WIDTH-1:0] negate(input logic [DATA_WIDTH-1:0] v);
    return (~v) + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] bool_word(input logic b);
    return {{(DATA_WIDTH-1){1'b0}}, b};
  endfunction

  state_t                state_r;
  logic                  out_valid_r;
  logic                  zero_r;
  logic [DATA_WIDTH-1:0] res_r;
  logic [DATA_WIDTH-1:0] quot_r;
  logic [DATA_WIDTH-1:0] rem_r;
  logic [DATA_WIDTH-1:0] divisor_r;
  logic [CW-1:0]         cnt_r;
  logic                  neg_q_r;
  logic                  neg_r_r;
  logic                  is_rem_r;

  logic                  accept_s;
  logic                  is_div_s;
  logic                  div_signed_s;
  logic                  div_zero_s;
  logic                  div_ovf_s;
  logic                  div_fast_s;
  logic [DATA_WIDTH-1:0] a_abs_s;
  logic [DATA_WIDTH-1:0] b_abs_s;
  logic [DATA_WIDTH-1:0] mul_s;
  logic [DATA_WIDTH-1:0] alu_s;
  logic [DATA_WIDTH:0]   rem_sh_s;
  logic [DATA_WIDTH:0]   diff_s;
  logic [DATA_WIDTH-1:0] q_nx_s;
  logic [DATA_WIDTH-1:0] r_nx_s;
  logic [DATA_WIDTH-1:0] div_res_s;

  // A new op is taken when idle, or when the held result is consumed in the same cycle.
  assign in_ready  = (state_r == IDLE) || ((state_r == DONE) && out_ready);
  assign accept_s  = in_valid && in_ready;
  assign out_valid = out_valid_r;
  assign ALUResult = res_r;
  assign Zero      = zero_r;

  assign is_div_s     = Operation[3] & Operation[2];
  assign div_signed_s = Operation[1];
  assign div_zero_s   = (SrcB == ZERO_V);
  assign div_ovf_s    = div_signed_s && (SrcA == MIN_V) && (SrcB == ONES_V);
  assign div_fast_s   = !ENABLE_DIV || div_zero_s || div_ovf_s;
  assign mul_s        = SrcA * SrcB;

  // Operand magnitudes handed to the iterative divider.
  always_comb begin
    a_abs_s = SrcA;
    b_abs_s = SrcB;
    if (div_signed_s && SrcA[DATA_WIDTH-1]) begin
      a_abs_s = negate(SrcA);
    end else begin
      a_abs_s = SrcA;
    end
    if (div_signed_s && SrcB[DATA_WIDTH-1]) begin
      b_abs_s = negate(SrcB);
    end else begin
      b_abs_s = SrcB;
    end
  end

  // Single-cycle result, including the divide cases resolved without iterating.
  always_comb begin
    alu_s = ZERO_V;
    case (Operation)
      4'b0000: alu_s = SrcA & SrcB;
      4'b0001: alu_s = SrcA | SrcB;
      4'b0010: alu_s = SrcA + SrcB;
      4'b0011: alu_s = SrcA ^ SrcB;
      4'b0100: alu_s = SrcA << SrcB[SW-1:0];
      4'b0101: alu_s = SrcA >> SrcB[SW-1:0];
      4'b0110: alu_s = SrcA - SrcB;
      4'b0111: alu_s = bool_word($signed(SrcA) < $signed(SrcB));
      4'b1000: alu_s = bool_word(SrcA == SrcB);
      4'b1001: alu_s = $signed(SrcA) >>> SrcB[SW-1:0];
      4'b1010: alu_s = bool_word(SrcA < SrcB);
      4'b1011: alu_s = mul_s;
      4'b1100, 4'b1101, 4'b1110, 4'b1111: begin
        if (!ENABLE_DIV) begin
          alu_s = ZERO_V;
        end else if (div_zero_s) begin
          alu_s = Operation[0] ? SrcA : ONES_V;
        end else if (div_ovf_s) begin
          alu_s = Operation[0] ? ZERO_V : MIN_V;
        end else begin
          alu_s = ZERO_V;
        end
      end
      default: alu_s = ZERO_V;
    endcase
  end

  // One restoring shift-subtract step; the final step also applies the sign fixup.
  always_comb begin
    rem_sh_s = {rem_r, quot_r[DATA_WIDTH-1]};
    diff_s   = rem_sh_s - {1'b0, divisor_r};
    q_nx_s   = {quot_r[DATA_WIDTH-2:0], ~diff_s[DATA_WIDTH]};
    if (diff_s[DATA_WIDTH]) begin
      r_nx_s = rem_sh_s[DATA_WIDTH-1:0];
    end else begin
      r_nx_s = diff_s[DATA_WIDTH-1:0];
    end
    if (is_rem_r) begin
      div_res_s = neg_r_r ? negate(r_nx_s) : r_nx_s;
    end else begin
      div_res_s = neg_q_r ? negate(q_nx_s) : q_nx_s;
    end
  end

  // Control FSM with registered result, Zero flag and out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      out_valid_r <= 1'b0;
      res_r       <= ZERO_V;
      zero_r      <= 1'b1;
      quot_r      <= ZERO_V;
      rem_r       <= ZERO_V;
      divisor_r   <= ZERO_V;
      cnt_r       <= {CW{1'b0}};
      neg_q_r     <= 1'b0;
      neg_r_r     <= 1'b0;
      is_rem_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (accept_s) begin
            if (is_div_s && !div_fast_s) begin
              state_r     <= DIV;
              out_valid_r <= 1'b0;
              quot_r      <= a_abs_s;
              rem_r       <= ZERO_V;
              divisor_r   <= b_abs_s;
              cnt_r       <= CNT_LOAD;
              neg_q_r     <= div_signed_s & (SrcA[DATA_WIDTH-1] ^ SrcB[DATA_WIDTH-1]);
              neg_r_r     <= div_signed_s & SrcA[DATA_WIDTH-1];
              is_rem_r    <= Operation[0];
            end else begin
              state_r     <= DONE;
              out_valid_r <= 1'b1;
              res_r       <= alu_s;
              zero_r      <= (alu_s == ZERO_V);
            end
          end else if ((state_r == DONE) && out_ready) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
          end else begin
            state_r     <= state_r;
          end
        end
        DIV: begin
          quot_r <= q_nx_s;
          rem_r  <= r_nx_s;
          cnt_r  <= cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            state_r     <= DONE;
            out_valid_r <= 1'b1;
            res_r       <= div_res_s;
            zero_r      <= (div_res_s == ZERO_V);
          end else begin
            state_r     <= DIV;
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle: vector table plus back-to-back,
// backpressure and reset-during-divide sequences.
module tb_alu_multicycle;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic         in_ready, out_valid, Zero;
  logic [W-1:0] SrcA = '0, SrcB = '0, ALUResult;
  logic [3:0]   Operation = 4'b0000;

  always #5 clk = ~clk;

  alu_multicycle #(.DATA_WIDTH(W), .OPCODE_LENGTH(4), .ENABLE_DIV(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation), .out_valid(out_valid),
    .out_ready(out_ready), .ALUResult(ALUResult), .Zero(Zero)
  );

  typedef struct {
    string        name;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    int           lat;
  } vec_t;

  vec_t tbl[$];
  vec_t bb[5];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one op with out_ready=1, scramble inputs after accept, wait for the result.
  task automatic apply(input vec_t v);
    int cyc;
    bit busy_ok;
    @(negedge clk);
    check({v.name, " in_ready"}, W'(in_ready), 32'd1);
    Operation = v.op; SrcA = v.a; SrcB = v.b; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; SrcA = ~v.a; SrcB = v.b + 32'd3; Operation = ~v.op;
    cyc = 1;
    busy_ok = 1'b1;
    while (!out_valid && cyc < 100) begin
      if (in_ready) busy_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check({v.name, " latency"}, W'(cyc), W'(v.lat));
    check({v.name, " result"}, ALUResult, v.exp);
    check({v.name, " zero"}, W'(Zero), W'(v.exp == 32'd0));
    if (v.lat > 1) check({v.name, " in_ready low while busy"}, W'(busy_ok), 32'd1);
  endtask

  initial begin
    tbl.push_back('{"and",    4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1});
    tbl.push_back('{"or",     4'b0001, 32'h0F0F0000, 32'h000000FF, 32'h0F0F00FF, 1});
    tbl.push_back('{"add wrap", 4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1});
    tbl.push_back('{"xor",    4'b0011, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1});
    tbl.push_back('{"sll mask", 4'b0100, 32'h00000001, 32'h00000021, 32'h00000002, 1});
    tbl.push_back('{"srl 31", 4'b0101, 32'h80000000, 32'h0000001F, 32'h00000001, 1});
    tbl.push_back('{"sub",    4'b0110, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1});
    tbl.push_back('{"slt",    4'b0111, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1});
    tbl.push_back('{"eq hit", 4'b1000, 32'h00001234, 32'h00001234, 32'h00000001, 1});
    tbl.push_back('{"eq miss", 4'b1000, 32'h00001234, 32'h00001235, 32'h00000000, 1});
    tbl.push_back('{"sra",    4'b1001, 32'h80000000, 32'h00000004, 32'hF8000000, 1});
    tbl.push_back('{"sltu",   4'b1010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1});
    tbl.push_back('{"mul neg", 4'b1011, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 1});
    tbl.push_back('{"divu by0", 4'b1100, 32'h0000000A, 32'h00000000, 32'hFFFFFFFF, 1});
    tbl.push_back('{"remu by0", 4'b1101, 32'h0000000A, 32'h00000000, 32'h0000000A, 1});
    tbl.push_back('{"div ovf", 4'b1110, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
    tbl.push_back('{"rem ovf", 4'b1111, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1});
    tbl.push_back('{"div by0", 4'b1110, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1});
    tbl.push_back('{"div -7/2", 4'b1110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33});
    tbl.push_back('{"rem -7/2", 4'b1111, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33});
    tbl.push_back('{"div 7/-2", 4'b1110, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 33});
    tbl.push_back('{"rem 7/-2", 4'b1111, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 33});
    tbl.push_back('{"divu 100/7", 4'b1100, 32'h00000064, 32'h00000007, 32'h0000000E, 33});
    tbl.push_back('{"remu 100/7", 4'b1101, 32'h00000064, 32'h00000007, 32'h00000002, 33});
    tbl.push_back('{"divu max/1", 4'b1100, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 33});
    tbl.push_back('{"remu max/16", 4'b1101, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 33});
    tbl.push_back('{"div exact", 4'b1110, 32'hFFFFFFF4, 32'h00000004, 32'hFFFFFFFD, 33});
    tbl.push_back('{"rem exact", 4'b1111, 32'hFFFFFFF4, 32'h00000004, 32'h00000000, 33});

    bb[0] = '{"b2b add",  4'b0010, 32'd5,        32'd7,        32'd12,        1};
    bb[1] = '{"b2b sub",  4'b0110, 32'd3,        32'd5,        32'hFFFFFFFE,  1};
    bb[2] = '{"b2b sra",  4'b1001, 32'h80000000, 32'd4,        32'hF8000000,  1};
    bb[3] = '{"b2b slt",  4'b0111, 32'hFFFFFFFF, 32'd1,        32'd1,         1};
    bb[4] = '{"b2b sltu", 4'b1010, 32'hFFFFFFFF, 32'd1,        32'd0,         1};

    // Reset state, then idle after release.
    #12;
    check("rst out_valid", W'(out_valid), 32'd0);
    check("rst result", ALUResult, 32'd0);
    check("rst zero", W'(Zero), 32'd1);
    check("rst in_ready", W'(in_ready), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle out_valid", W'(out_valid), 32'd0);
    check("idle result", ALUResult, 32'd0);
    check("idle zero", W'(Zero), 32'd1);

    foreach (tbl[i]) apply(tbl[i]);

    // Back-to-back, one result per cycle.
    @(negedge clk);
    Operation = bb[0].op; SrcA = bb[0].a; SrcB = bb[0].b; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check({bb[i].name, " valid"}, W'(out_valid), 32'd1);
      check({bb[i].name, " result"}, ALUResult, bb[i].exp);
      check({bb[i].name, " in_ready"}, W'(in_ready), 32'd1);
      if (i < 4) begin
        Operation = bb[i+1].op; SrcA = bb[i+1].a; SrcB = bb[i+1].b;
      end else begin
        in_valid = 1'b0;
      end
    end

    // Backpressure: result held while out_ready is low.
    @(negedge clk);
    out_ready = 1'b0;
    Operation = 4'b1011; SrcA = 32'h00010000; SrcB = 32'h00010000; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; SrcA = 32'd2; SrcB = 32'd3; Operation = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      check("bp out_valid", W'(out_valid), 32'd1);
      check("bp result", ALUResult, 32'd0);
      check("bp zero", W'(Zero), 32'd1);
      check("bp in_ready", W'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1; in_valid = 1'b1;
    #1 check("bp release in_ready", W'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp next valid", W'(out_valid), 32'd1);
    check("bp next result", ALUResult, 32'd5);
    check("bp next zero", W'(Zero), 32'd0);

    // Reset asserted in the middle of a divide.
    @(negedge clk);
    Operation = 4'b1100; SrcA = 32'd100; SrcB = 32'd7; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("mid-div in_ready", W'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("abort out_valid", W'(out_valid), 32'd0);
    check("abort result", ALUResult, 32'd0);
    check("abort in_ready", W'(in_ready), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    begin
      bit quiet;
      quiet = 1'b1;
      repeat (40) begin
        @(negedge clk);
        if (out_valid) quiet = 1'b0;
      end
      check("abort no stale result", W'(quiet), 32'd1);
    end
    apply('{"post-reset add", 4'b0010, 32'd1, 32'd1, 32'd2, 1});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
